local_pattern_master: RTL and testbench

LOCAL_PATTERN_MASTER -- requirements
Module: local_pattern_master

---
 rtl/local_pattern_master_if.sv | 34 +++
 rtl/local_pattern_master.sv | 262 ++++++++++++++++++++++++++
 tb/tb_local_pattern_master.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/local_pattern_master_if.sv
// ---------------------------------------------------------------------------
// local_pattern_master_if
// Local-side bus between a pattern master and a memory controller.
//   Request side (master drives): local_address[24:0], local_size[2:0],
//     local_be[3:0], local_wdata[31:0], local_write_req, local_read_req,
//     local_burstbegin
//   Status/response side (controller drives): local_init_done, local_ready,
//     local_rdata_valid, local_rdata[31:0]
// ---------------------------------------------------------------------------
interface local_pattern_master_if;
  logic [24:0] local_address;
  logic [2:0]  local_size;
  logic [3:0]  local_be;
  logic [31:0] local_wdata;
  logic        local_write_req;
  logic        local_read_req;
  logic        local_burstbegin;
  logic        local_init_done;
  logic        local_ready;
  logic        local_rdata_valid;
  logic [31:0] local_rdata;

  modport master (
    output local_address, local_size, local_be, local_wdata,
           local_write_req, local_read_req, local_burstbegin,
    input  local_init_done, local_ready, local_rdata_valid, local_rdata
  );

  modport slave (
    input  local_address, local_size, local_be, local_wdata,
           local_write_req, local_read_req, local_burstbegin,
    output local_init_done, local_ready, local_rdata_valid, local_rdata
  );
endinterface

// File: rtl/local_pattern_master.sv
// ---------------------------------------------------------------------------
// local_pattern_master
// Writes a deterministic pattern (PATTERN_SEED ^ global beat index) over
// num_bursts bursts of BURST_LEN beats starting at base_addr, and, when the
// PATTERN_CHECK_EN macro is defined, reads the region back one burst at a
// time and counts mismatching words. Without PATTERN_CHECK_EN the read-back
// states and comparator are not built, the run ends after the writes, and
// err_count / first_err_addr are tied to zero.
//
// Ports
//   phy_clk         controller clock
//   reset           asynchronous, active-high
//   start           run request, sampled only while idle
//   base_addr[24:0] first word address, latched at start
//   num_bursts[15:0] burst count, latched at start (0 = 65536)
//   busy, done      run status (done is a one-cycle pulse)
//   err_count[15:0] saturating mismatch count of the last run
//   first_err_addr[24:0] burst address of the first mismatch
//   bus             local_pattern_master_if.master controller port
// ---------------------------------------------------------------------------
module local_pattern_master #(
  parameter int unsigned BURST_LEN    = 2,
  parameter logic [31:0] PATTERN_SEED = 32'hA5A5_0000
) (
  input  logic        phy_clk,
  input  logic        reset,
  input  logic        start,
  input  logic [24:0] base_addr,
  input  logic [15:0] num_bursts,
  output logic        busy,
  output logic        done,
  output logic [15:0] err_count,
  output logic [24:0] first_err_addr,
  local_pattern_master_if.master bus
);

  localparam logic [2:0]  SIZE_C      = 3'(BURST_LEN);
  localparam logic [1:0]  LAST_BEAT_C = 2'(BURST_LEN - 1);
  localparam logic [24:0] ADDR_STEP_C = 25'(BURST_LEN);

`ifdef PATTERN_CHECK_EN
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_INIT = 3'd1,
    WR        = 3'd2,
    RD_REQ    = 3'd3,
    RD_DATA   = 3'd4,
    FINISH    = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_INIT = 3'd1,
    WR        = 3'd2,
    FINISH    = 3'd5
  } state_t;
`endif

  state_t      state_r;
  logic [24:0] addr_r;        // current burst address, constant across its beats
  logic [31:0] wdata_r;
  logic [3:0]  be_r;
  logic        wr_req_r;
  logic        bb_r;
  logic        busy_r;
  logic        done_r;
  logic [24:0] base_r;
  logic [16:0] total_r;       // 17 bits so that 65536 bursts is representable
  logic [16:0] bursts_rem_r;  // bursts left including the current one
  logic [1:0]  beat_r;        // beat position inside the current burst
  logic [18:0] gbeat_r;       // global beat index of the current/expected word
  logic [18:0] gbeat_next_s;
  logic [31:0] wdata_next_s;

  assign gbeat_next_s = gbeat_r + 19'd1;
  assign wdata_next_s = PATTERN_SEED ^ {13'd0, gbeat_next_s};

`ifdef PATTERN_CHECK_EN
  logic        rd_req_r;
  logic [15:0] err_cnt_r;
  logic [24:0] first_err_r;
  logic        err_seen_r;
  logic [31:0] exp_rdata_s;

  assign exp_rdata_s = PATTERN_SEED ^ {13'd0, gbeat_r};
`endif

  // Run sequencer: owns every request and status register.
  always_ff @(posedge phy_clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      addr_r       <= 25'd0;
      wdata_r      <= 32'd0;
      be_r         <= 4'h0;
      wr_req_r     <= 1'b0;
      bb_r         <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      base_r       <= 25'd0;
      total_r      <= 17'd0;
      bursts_rem_r <= 17'd0;
      beat_r       <= 2'd0;
      gbeat_r      <= 19'd0;
`ifdef PATTERN_CHECK_EN
      rd_req_r     <= 1'b0;
      err_cnt_r    <= 16'd0;
      first_err_r  <= 25'd0;
      err_seen_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            base_r  <= base_addr;
            total_r <= (num_bursts == 16'd0) ? 17'h1_0000 : {1'b0, num_bursts};
            busy_r  <= 1'b1;
            state_r <= WAIT_INIT;
`ifdef PATTERN_CHECK_EN
            err_cnt_r   <= 16'd0;
            first_err_r <= 25'd0;
            err_seen_r  <= 1'b0;
`endif
          end
        end

        WAIT_INIT: begin
          if (bus.local_init_done) begin
            state_r      <= WR;
            wr_req_r     <= 1'b1;
            be_r         <= 4'hF;
            bb_r         <= 1'b1;
            addr_r       <= base_r;
            wdata_r      <= PATTERN_SEED;
            gbeat_r      <= 19'd0;
            beat_r       <= 2'd0;
            bursts_rem_r <= total_r;
          end
        end

        WR: begin
          // Outputs only move on an accepted beat, so they hold while stalled.
          if (wr_req_r && bus.local_ready) begin
            if (beat_r == LAST_BEAT_C) begin
              if (bursts_rem_r == 17'd1) begin
                wr_req_r <= 1'b0;
                be_r     <= 4'h0;
`ifdef PATTERN_CHECK_EN
                // Read-back restarts from the first burst.
                state_r      <= RD_REQ;
                rd_req_r     <= 1'b1;
                bb_r         <= 1'b1;
                addr_r       <= base_r;
                gbeat_r      <= 19'd0;
                beat_r       <= 2'd0;
                bursts_rem_r <= total_r;
`else
                state_r <= FINISH;
                bb_r    <= 1'b0;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
`endif
              end else begin
                addr_r       <= addr_r + ADDR_STEP_C;
                bb_r         <= 1'b1;
                beat_r       <= 2'd0;
                bursts_rem_r <= bursts_rem_r - 17'd1;
                gbeat_r      <= gbeat_next_s;
                wdata_r      <= wdata_next_s;
              end
            end else begin
              bb_r    <= 1'b0;
              beat_r  <= beat_r + 2'd1;
              gbeat_r <= gbeat_next_s;
              wdata_r <= wdata_next_s;
            end
          end
        end

`ifdef PATTERN_CHECK_EN
        RD_REQ: begin
          if (rd_req_r && bus.local_ready) begin
            rd_req_r <= 1'b0;
            bb_r     <= 1'b0;
            beat_r   <= 2'd0;
            state_r  <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (bus.local_rdata_valid) begin
            if (bus.local_rdata != exp_rdata_s) begin
              if (err_cnt_r != 16'hFFFF) begin
                err_cnt_r <= err_cnt_r + 16'd1;
              end
              if (!err_seen_r) begin
                err_seen_r  <= 1'b1;
                first_err_r <= addr_r;
              end
            end
            gbeat_r <= gbeat_next_s;
            if (beat_r == LAST_BEAT_C) begin
              if (bursts_rem_r == 17'd1) begin
                state_r <= FINISH;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
              end else begin
                // Next request only after the whole burst returned.
                addr_r       <= addr_r + ADDR_STEP_C;
                rd_req_r     <= 1'b1;
                bb_r         <= 1'b1;
                bursts_rem_r <= bursts_rem_r - 17'd1;
                state_r      <= RD_REQ;
              end
            end else begin
              beat_r <= beat_r + 2'd1;
            end
          end
        end
`endif

        FINISH: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end

        default: begin
          state_r  <= IDLE;
          wr_req_r <= 1'b0;
          bb_r     <= 1'b0;
          be_r     <= 4'h0;
          busy_r   <= 1'b0;
          done_r   <= 1'b0;
`ifdef PATTERN_CHECK_EN
          rd_req_r <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign bus.local_address    = addr_r;
  assign bus.local_size       = SIZE_C;
  assign bus.local_be         = be_r;
  assign bus.local_wdata      = wdata_r;
  assign bus.local_write_req  = wr_req_r;
  assign bus.local_burstbegin = bb_r;
  assign busy                 = busy_r;
  assign done                 = done_r;

`ifdef PATTERN_CHECK_EN
  assign bus.local_read_req = rd_req_r;
  assign err_count          = err_cnt_r;
  assign first_err_addr     = first_err_r;
`else
  logic unused_rd_s;
  assign unused_rd_s        = ^{bus.local_rdata, bus.local_rdata_valid};
  assign bus.local_read_req = 1'b0;
  assign err_count          = 16'd0;
  assign first_err_addr     = 25'd0;
`endif

endmodule

// File: tb/tb_local_pattern_master.sv
// ---------------------------------------------------------------------------
// tb_local_pattern_master
// Directed scenarios against local_pattern_master with a behavioural
// controller/memory model. Expected write beats are queued when a run is
// started and popped as the DUT presents accepted beats.
// ---------------------------------------------------------------------------
module tb_local_pattern_master;
  localparam int          BL   = 2;
  localparam logic [31:0] SEED = 32'hA5A5_0000;

  logic        phy_clk = 1'b0;
  logic        reset;
  logic        start;
  logic [24:0] base_addr;
  logic [15:0] num_bursts;
  logic        busy;
  logic        done;
  logic [15:0] err_count;
  logic [24:0] first_err_addr;

  local_pattern_master_if bus();

  local_pattern_master #(.BURST_LEN(BL), .PATTERN_SEED(SEED)) dut (
    .phy_clk        (phy_clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .num_bursts     (num_bursts),
    .busy           (busy),
    .done           (done),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .bus            (bus)
  );

  always #5 phy_clk = ~phy_clk;

  typedef struct packed {
    logic [24:0] addr;
    logic [31:0] data;
    logic        bb;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] pend_q[$];
  logic [24:0] bb_addr_q[$];
  logic [31:0] mem [logic [24:0]];

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int wr_acc, rd_acc, rd_beats, done_cnt, both_cnt, stall_done;
  int stall_beat   = -1;
  int stall_cycles = 3;
  int corrupt_beat = -1;
  bit run_finished;
  bit spurious_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Controller/memory model and write scoreboard, evaluated on the falling edge.
  initial begin : model
    logic [24:0] cur_burst;
    logic [24:0] a;
    logic [31:0] d;
    int          beat_in_burst;
    beat_t       e;
    cur_burst = 25'd0;
    beat_in_burst = 0;
    bus.local_ready       = 1'b1;
    bus.local_rdata_valid = 1'b0;
    bus.local_rdata       = 32'd0;
    forever begin
      @(negedge phy_clk);
      if (reset) begin
        bus.local_ready       = 1'b1;
        bus.local_rdata_valid = 1'b0;
      end else begin
        if (bus.local_write_req && bus.local_read_req) both_cnt++;
        if (done) begin
          done_cnt++;
          run_finished = 1'b1;
        end
        if (pend_q.size() > 0) begin
          bus.local_rdata_valid = 1'b1;
          bus.local_rdata       = pend_q.pop_front();
        end else if (spurious_en) begin
          bus.local_rdata_valid = 1'b1;
          bus.local_rdata       = 32'd0;
        end else begin
          bus.local_rdata_valid = 1'b0;
        end
        if (bus.local_write_req && wr_acc == stall_beat && stall_done < stall_cycles) begin
          bus.local_ready = 1'b0;
          stall_done++;
          if (exp_q.size() > 0) begin
            e = exp_q[0];
            chk("stall_addr", bus.local_address, e.addr);
            chk("stall_data", bus.local_wdata, e.data);
            chk("stall_bb", bus.local_burstbegin, e.bb);
          end
        end else begin
          bus.local_ready = 1'b1;
        end
        if (bus.local_write_req && bus.local_ready) begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wr_addr", bus.local_address, e.addr);
            chk("wr_data", bus.local_wdata, e.data);
            chk("wr_bb", bus.local_burstbegin, e.bb);
            chk("wr_be", bus.local_be, 4'hF);
          end else begin
            chk("wr_extra_beat", exp_q.size(), 1);
          end
          if (bus.local_burstbegin) begin
            cur_burst = bus.local_address;
            beat_in_burst = 0;
            bb_addr_q.push_back(bus.local_address);
          end else begin
            beat_in_burst++;
          end
          mem[cur_burst + 25'(beat_in_burst)] = bus.local_wdata;
          wr_acc++;
        end
        if (bus.local_read_req && bus.local_ready) begin
          chk("rd_bb", bus.local_burstbegin, 1'b1);
          for (int k = 0; k < BL; k++) begin
            a = bus.local_address + 25'(k);
            d = mem.exists(a) ? mem[a] : 32'd0;
            if (rd_beats == corrupt_beat) d = 32'd0;
            pend_q.push_back(d);
            rd_beats++;
          end
          rd_acc++;
        end
      end
    end
  end

  task automatic step();
    @(posedge phy_clk);
    #2;
  endtask

  task automatic start_run(input logic [24:0] base, input int nb);
    beat_t e;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < BL; k++) begin
        e.addr = base + 25'(b * BL);
        e.data = SEED ^ 32'(b * BL + k);
        e.bb   = (k == 0);
        exp_q.push_back(e);
      end
    end
    wr_acc = 0; rd_acc = 0; rd_beats = 0; done_cnt = 0; both_cnt = 0; stall_done = 0;
    run_finished = 1'b0;
    bb_addr_q.delete();
    base_addr  = base;
    num_bursts = 16'(nb);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic end_run(input string tag, input int nb, input logic [15:0] exp_err,
                         input logic [24:0] exp_first);
    int n;
    int exp_rd;
    n = 0;
    while (!run_finished && n < 3000) begin
      step();
      n++;
    end
    chk({tag, "_done_timeout"}, run_finished, 1'b1);
    repeat (3) step();
`ifdef PATTERN_CHECK_EN
    exp_rd = nb;
`else
    exp_rd = 0;
`endif
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done_low"}, done, 1'b0);
    chk({tag, "_beats_left"}, exp_q.size(), 0);
    chk({tag, "_wr_beats"}, wr_acc, nb * BL);
    chk({tag, "_rd_bursts"}, rd_acc, exp_rd);
    chk({tag, "_wr_rd_overlap"}, both_cnt, 0);
    chk({tag, "_err_count"}, err_count, exp_err);
    chk({tag, "_first_err_addr"}, first_err_addr, exp_first);
  endtask

  // Directed scenario sequence.
  initial begin : stim
    int n;
    int viol;
    reset = 1'b1;
    start = 1'b0;
    base_addr = 25'd0;
    num_bursts = 16'd0;
    bus.local_init_done = 1'b1;
    repeat (3) step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_wr_req", bus.local_write_req, 1'b0);
    chk("rst_rd_req", bus.local_read_req, 1'b0);
    chk("rst_bb", bus.local_burstbegin, 1'b0);
    chk("rst_be", bus.local_be, 4'h0);
    chk("rst_size", bus.local_size, 3'(BL));
    chk("rst_err", err_count, 16'd0);
    chk("rst_first", first_err_addr, 25'd0);
    reset = 1'b0;
    step();

    // Scenario 1: always-ready controller, stray read-valid outside read-back.
    spurious_en = 1'b1;
    start_run(25'd0, 4);
    end_run("s1", 4, 16'd0, 25'd0);
    spurious_en = 1'b0;

    // Scenario 2: second write beat stalled for three cycles.
    stall_beat = 1;
    start_run(25'd0, 4);
    end_run("s2", 4, 16'd0, 25'd0);
    chk("s2_stall_cycles", stall_done, stall_cycles);
    stall_beat = -1;

`ifdef PATTERN_CHECK_EN
    // Scenario 3: read beat 5 returned corrupted.
    corrupt_beat = 5;
    start_run(25'd0, 4);
    end_run("s3", 4, 16'd1, 25'((5 / BL) * BL));
    corrupt_beat = -1;
`endif

    // Scenario 4: address wrap; error status cleared by the new start.
    start_run(25'h1FF_FFFE, 2);
    chk("s4_err_cleared", err_count, 16'd0);
    chk("s4_first_cleared", first_err_addr, 25'd0);
    end_run("s4", 2, 16'd0, 25'd0);
    chk("s4_burst_count", bb_addr_q.size(), 2);
    if (bb_addr_q.size() == 2) begin
      chk("s4_burst0_addr", bb_addr_q[0], 25'h1FF_FFFE);
      chk("s4_burst1_addr", bb_addr_q[1], 25'h000_0000);
    end

    // Scenario 5: reset in the middle of the run.
    start_run(25'd0, 4);
    n = 0;
`ifdef PATTERN_CHECK_EN
    while (rd_acc < 2 && n < 1000) begin step(); n++; end
    chk("s5_reached_rd", rd_acc >= 2, 1'b1);
`else
    while (wr_acc < 3 && n < 1000) begin step(); n++; end
    chk("s5_reached_wr", wr_acc >= 3, 1'b1);
`endif
    reset = 1'b1;
    #1;
    chk("s5_busy", busy, 1'b0);
    chk("s5_wr_req", bus.local_write_req, 1'b0);
    chk("s5_rd_req", bus.local_read_req, 1'b0);
    chk("s5_bb", bus.local_burstbegin, 1'b0);
    chk("s5_be", bus.local_be, 4'h0);
    chk("s5_err", err_count, 16'd0);
    exp_q.delete();
    pend_q.delete();
    repeat (4) step();
    chk("s5_wr_req_held", bus.local_write_req, 1'b0);
    reset = 1'b0;
    step();
    start_run(25'd0, 4);
    end_run("s5_rerun", 4, 16'd0, 25'd0);

    // Scenario 6: controller not initialised for 100 cycles; extra start ignored.
    bus.local_init_done = 1'b0;
    start_run(25'h40, 2);
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.local_write_req || bus.local_read_req) viol++;
      if (!busy) viol++;
      start = (i == 50);
      if (i == 50) base_addr = 25'h123;
      step();
    end
    start = 1'b0;
    chk("s6_idle_while_uninit", viol, 0);
    bus.local_init_done = 1'b1;
    end_run("s6", 2, 16'd0, 25'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
